// File: rtl/cms_pkg.sv
// cms_pkg: shared field offsets, framing state and packet type for the CMS trace receiver.
package cms_pkg;
   localparam int PC_LSB    = 32;
   localparam int INSTR_MSB = 31;

   typedef enum logic [1:0] {IDLE, FRAME, RESYNC} rx_state_t;

   typedef struct packed {
      logic [63:0] pc;
      logic [31:0] instr;
      logic        last;
   } trace_pkt_t;
endpackage

// File: rtl/cms_rx_fifo.sv
// cms_rx_fifo: synchronous FIFO with wrap-bit pointers; head entry is read combinationally.
module cms_rx_fifo #(
   parameter int WIDTH = 97,
   parameter int DEPTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);
   localparam int AW = $clog2(DEPTH);

   logic [AW:0]      wptr_q, wptr_d, rptr_q, rptr_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             do_push, do_pop;

   always_comb begin
      full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
      empty   = wptr_q == rptr_q;
      do_push = push && !full;
      do_pop  = pop && !empty;
      wptr_d  = wptr_q + {{AW{1'b0}}, do_push};
      rptr_d  = rptr_q + {{AW{1'b0}}, do_pop};
      dout    = empty ? '0 : mem_q[rptr_q[AW-1:0]];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr_q <= '0;
         rptr_q <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
      end
   end

   // Storage needs no reset: empty gates the head output.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wptr_q[AW-1:0]] <= din;
   end
endmodule

// File: rtl/cms_trace_rx.sv
// cms_trace_rx: AXI-Stream trace receiver with FIFO, pc/instr pop port and tlast framing check.
// Define CMS_RX_ALWAYS_READY_EN to keep tready high, drop beats when full and expose drop_count.
module cms_trace_rx
   import cms_pkg::*;
#(
   parameter int XLEN           = 64,
   parameter int AXI_DATA_WIDTH = XLEN + 32,
   parameter int FIFO_DEPTH     = 8
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      S_AXIS_tvalid,
   output logic                      S_AXIS_tready,
   input  logic [AXI_DATA_WIDTH-1:0] S_AXIS_tdata,
   input  logic                      S_AXIS_tlast,
   input  logic [31:0]               tlast_interval,
   output logic                      pkt_valid,
   input  logic                      pkt_ready,
   output logic [XLEN-1:0]           pkt_pc,
   output logic [31:0]               pkt_instr,
   output logic                      pkt_last,
   output logic [31:0]               frame_count,
   output logic                      err_early,
   output logic                      err_late,
`ifdef CMS_RX_ALWAYS_READY_EN
   output logic [31:0]               drop_count,
`endif
   input  logic                      clear_errors
);
   localparam int W = AXI_DATA_WIDTH + 1;

   logic          full, empty, rdy_q, beat, push;
   logic [W-1:0]  head;
   rx_state_t     state_q, state_d;
   logic [31:0]   cnt_q, cnt_d, nxt, fc_q, fc_d;
   logic          ee_q, ee_d, el_q, el_d;

   assign beat = S_AXIS_tvalid && S_AXIS_tready;

`ifdef CMS_RX_ALWAYS_READY_EN
   logic [31:0] drop_q, drop_d;
   assign S_AXIS_tready = rdy_q;
   assign push          = beat && !full;
   assign drop_d        = (beat && full && !(&drop_q)) ? drop_q + 32'd1 : drop_q;
   assign drop_count    = drop_q;
`else
   assign S_AXIS_tready = rdy_q && !full;
   assign push          = beat;
`endif

   cms_rx_fifo #(.WIDTH(W), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .din   ({S_AXIS_tlast, S_AXIS_tdata}),
      .pop   (pkt_ready),
      .dout  (head),
      .full  (full),
      .empty (empty)
   );

   assign pkt_valid   = !empty;
   assign pkt_pc      = head[PC_LSB +: XLEN];
   assign pkt_instr   = head[INSTR_MSB:0];
   assign pkt_last    = head[W-1];
   assign frame_count = fc_q;
   assign err_early   = ee_q;
   assign err_late    = el_q;

   // nxt is the position of the current beat within its frame.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      fc_d    = fc_q;
      ee_d    = ee_q && !clear_errors;
      el_d    = el_q && !clear_errors;
      nxt     = (state_q == IDLE) ? 32'd1 : (&cnt_q ? cnt_q : cnt_q + 32'd1);
      if (beat) begin
         if (tlast_interval == 32'd0) begin
            state_d = IDLE;
            cnt_d   = '0;
            fc_d    = fc_q + {31'd0, S_AXIS_tlast};
         end else if (state_q == RESYNC) begin
            state_d = S_AXIS_tlast ? IDLE : RESYNC;
            cnt_d   = S_AXIS_tlast ? '0 : cnt_q;
         end else if (S_AXIS_tlast) begin
            state_d = IDLE;
            cnt_d   = '0;
            if (nxt == tlast_interval) fc_d = fc_q + 32'd1;
            else if (nxt < tlast_interval) ee_d = 1'b1;
            else el_d = 1'b1;
         end else begin
            state_d = (nxt >= tlast_interval) ? RESYNC : FRAME;
            cnt_d   = nxt;
            el_d    = el_d || (nxt >= tlast_interval);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdy_q   <= 1'b0;
         state_q <= IDLE;
         cnt_q   <= '0;
         fc_q    <= '0;
         ee_q    <= 1'b0;
         el_q    <= 1'b0;
`ifdef CMS_RX_ALWAYS_READY_EN
         drop_q  <= '0;
`endif
      end else begin
         rdy_q   <= 1'b1;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         fc_q    <= fc_d;
         ee_q    <= ee_d;
         el_q    <= el_d;
`ifdef CMS_RX_ALWAYS_READY_EN
         drop_q  <= drop_d;
`endif
      end
   end
endmodule

// File: tb/tb_cms_trace_rx.sv
// tb_cms_trace_rx: directed and random checks of cms_trace_rx against a queue-and-position model.
module tb_cms_trace_rx;
   localparam int XLEN = 64, DW = XLEN + 32, DEPTH = 8;

   logic            clk = 0, rst_n = 1;
   logic            S_AXIS_tvalid = 0, S_AXIS_tlast = 0, pkt_ready = 0, clear_errors = 0;
   logic [DW-1:0]   S_AXIS_tdata = '0;
   logic [31:0]     tlast_interval = 0;
   logic            S_AXIS_tready, pkt_valid, pkt_last, err_early, err_late;
   logic [XLEN-1:0] pkt_pc;
   logic [31:0]     pkt_instr, frame_count;

   int          checks = 0, errors = 0;
   logic [DW:0] mq[$];
   bit          m_rdy, m_resync, m_early, m_late;
   longint      m_pos;
   logic [31:0] m_fc;

   always #5 clk = ~clk;

   cms_trace_rx dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .S_AXIS_tvalid  (S_AXIS_tvalid),
      .S_AXIS_tready  (S_AXIS_tready),
      .S_AXIS_tdata   (S_AXIS_tdata),
      .S_AXIS_tlast   (S_AXIS_tlast),
      .tlast_interval (tlast_interval),
      .pkt_valid      (pkt_valid),
      .pkt_ready      (pkt_ready),
      .pkt_pc         (pkt_pc),
      .pkt_instr      (pkt_instr),
      .pkt_last       (pkt_last),
      .frame_count    (frame_count),
      .err_early      (err_early),
      .err_late       (err_late),
      .clear_errors   (clear_errors)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input bit v, input logic [63:0] pc, input logic [31:0] ins, input bit last);
      S_AXIS_tvalid = v;
      S_AXIS_tdata  = {pc, ins};
      S_AXIS_tlast  = last;
   endtask

   // Frame rule: a frame is exactly tlast_interval beats ending in tlast.
   task automatic frame(input bit last, output bit se, output bit sl);
      longint iv = longint'(tlast_interval);
      se = 0;
      sl = 0;
      if (iv == 0) begin
         m_fc  += {31'd0, last};
         m_pos  = 0;
      end else if (m_resync) begin
         if (last) begin
            m_resync = 0;
            m_pos    = 0;
         end
      end else begin
         m_pos++;
         if (last) begin
            if (m_pos == iv) m_fc++;
            else if (m_pos < iv) se = 1;
            else sl = 1;
            m_pos = 0;
         end else if (m_pos >= iv) begin
            sl       = 1;
            m_resync = 1;
         end
      end
   endtask

   task automatic cmp();
      logic [DW:0] h = (mq.size() > 0) ? mq[0] : '0;
      chk("tready", S_AXIS_tready, m_rdy && mq.size() < DEPTH);
      chk("pkt_valid", pkt_valid, mq.size() > 0);
      chk("pkt_pc", pkt_pc, h[DW-1:32]);
      chk("pkt_instr", pkt_instr, h[31:0]);
      chk("pkt_last", pkt_last, h[DW]);
      chk("frame_count", frame_count, m_fc);
      chk("err_early", err_early, m_early);
      chk("err_late", err_late, m_late);
   endtask

   task automatic cyc();
      bit acc, pop, se, sl;
      acc = S_AXIS_tvalid && m_rdy && mq.size() < DEPTH;
      pop = pkt_ready && mq.size() > 0;
      se  = 0;
      sl  = 0;
      if (acc) frame(S_AXIS_tlast, se, sl);
      m_early = (m_early && !clear_errors) || se;
      m_late  = (m_late && !clear_errors) || sl;
      if (pop) void'(mq.pop_front());
      if (acc) mq.push_back({S_AXIS_tlast, S_AXIS_tdata});
      @(posedge clk);
      #1;
      m_rdy = 1;
      cmp();
   endtask

   task automatic do_reset();
      rst_n = 0;
      drive(0, 0, 0, 0);
      pkt_ready    = 0;
      clear_errors = 0;
      #2;
      mq.delete();
      m_rdy = 0; m_pos = 0; m_resync = 0; m_early = 0; m_late = 0; m_fc = 0;
      chk("rst_tready", S_AXIS_tready, 0);
      chk("rst_valid", pkt_valid, 0);
      chk("rst_pc", pkt_pc, 0);
      chk("rst_instr", pkt_instr, 0);
      chk("rst_fc", frame_count, 0);
      chk("rst_errs", {err_early, err_late}, 0);
      @(posedge clk);
      #1;
      rst_n = 1;
      cyc();
   endtask

   task automatic frame_beats(input int n, input int tl, input bit clr_on_last);
      for (int i = 1; i <= n; i++) begin
         drive(1, 64'(i * 16), 32'(i), i == tl);
         clear_errors = clr_on_last && (i == tl);
         cyc();
      end
      drive(0, 0, 0, 0);
      clear_errors = 0;
   endtask

   initial begin
      logic [63:0] eq[$];
      #1;
      do_reset();

      // single beat, interval 1
      tlast_interval = 1;
      drive(1, 64'h8, 32'h0000006f, 1);
      cyc();
      drive(0, 0, 0, 0);
      chk("t1_valid", pkt_valid, 1);
      chk("t1_pc", pkt_pc, 64'h8);
      chk("t1_instr", pkt_instr, 32'h6f);
      chk("t1_last", pkt_last, 1);
      chk("t1_fc", frame_count, 1);
      pkt_ready = 1;
      cyc();
      pkt_ready = 0;

      // backpressure
      tlast_interval = 0;
      for (int i = 1; i <= 8; i++) begin
         drive(1, 64'(4 * i), 32'(i), 0);
         cyc();
      end
      chk("bp_full", S_AXIS_tready, 0);
      drive(1, 64'd36, 32'd9, 0);
      cyc();
      cyc();
      chk("bp_held", S_AXIS_tready, 0);
      chk("bp_head", pkt_pc, 64'd4);
      pkt_ready = 1;
      cyc();
      pkt_ready = 0;
      chk("bp_room", S_AXIS_tready, 1);
      cyc();
      drive(0, 0, 0, 0);
      chk("bp_refull", S_AXIS_tready, 0);
      pkt_ready = 1;
      for (int i = 2; i <= 9; i++) begin
         chk("bp_order", pkt_pc, 64'(4 * i));
         cyc();
      end
      pkt_ready = 0;
      chk("bp_empty", pkt_valid, 0);

      // simultaneous push/pop at occupancy 3
      for (int i = 1; i <= 3; i++) begin
         drive(1, 64'(100 + i), 32'(i), 0);
         eq.push_back(64'(100 + i));
         cyc();
      end
      pkt_ready = 1;
      for (int i = 0; i < 10; i++) begin
         drive(1, 64'(200 + i), 32'(i), 0);
         eq.push_back(64'(200 + i));
         chk("pp_head", pkt_pc, eq.pop_front());
         cyc();
         chk("pp_ready", S_AXIS_tready, 1);
      end
      drive(0, 0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         chk("pp_drain", pkt_pc, eq.pop_front());
         cyc();
      end
      chk("pp_occ3", pkt_valid, 0);

      // early tlast, clear, clear vs new error
      tlast_interval = 4;
      frame_beats(2, 2, 0);
      chk("early_set", err_early, 1);
      chk("early_fc", frame_count, 1);
      clear_errors = 1;
      cyc();
      clear_errors = 0;
      chk("early_clr", err_early, 0);
      frame_beats(2, 2, 0);
      chk("early_again", err_early, 1);
      frame_beats(2, 2, 1);
      chk("early_clr_win", err_early, 1);
      clear_errors = 1;
      cyc();
      clear_errors = 0;

      // late tlast and resync
      frame_beats(4, 0, 0);
      chk("late_set", err_late, 1);
      chk("late_noearly", err_early, 0);
      frame_beats(2, 2, 0);
      chk("late_resync_fc", frame_count, 1);
      frame_beats(4, 4, 0);
      chk("late_next_fc", frame_count, 2);
      chk("late_sticky", err_late, 1);

      // reset mid-frame
      frame_beats(2, 0, 0);
      do_reset();
      tlast_interval = 4;
      frame_beats(4, 4, 0);
      chk("mid_fc", frame_count, 1);
      chk("mid_errs", {err_early, err_late}, 0);

      // random traffic
      for (int c = 0; c < 1500; c++) begin
         if (m_pos == 0 && !m_resync && $urandom_range(0, 15) == 0)
            tlast_interval = $urandom_range(0, 5);
         drive($urandom_range(0, 9) < 7, {$urandom(), $urandom()}, $urandom(), $urandom_range(0, 3) == 0);
         pkt_ready    = $urandom_range(0, 9) < 6;
         clear_errors = $urandom_range(0, 19) == 0;
         cyc();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
